// File: rtl/fp_mul_seq.sv
// Multicycle IEEE-754 multiplier: radix-2 shift-add significand product, then
// normalise and round-to-nearest-even, with valid/ready handshakes on both sides.
module fp_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   flp_a,
   input  logic [EXP_W+MAN_W:0]   flp_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   product,
   output logic                   flag_ovf,
   output logic                   flag_unf,
   output logic                   flag_inv,
   output logic                   flag_inx
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(SW + 1);
   localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
   localparam logic [CW-1:0]        LAST_ITER = CW'(SW - 1);
   localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;

   state_t                 state, next_state;
   logic                   sign_r;
   logic [SW-1:0]          ma_r;
   logic [PW-1:0]          prod_r;
   logic [CW-1:0]          cnt_r;
   logic signed [EW-1:0]   exp_r;
   logic [MAN_W-1:0]       frac_r;
   logic                   guard_r, sticky_r;
   logic [W-1:0]           product_r;
   logic [3:0]             flags_r;

   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       fa, fb;
   logic                   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic                   accept, special;
   logic [W-1:0]           spec_prod;
   logic                   spec_inv;
   logic [SW:0]            mul_sum;
   logic                   norm_msb;
   logic [MAN_W-1:0]       norm_frac;
   logic                   norm_guard, norm_sticky;
   logic                   round_up;
   logic [MAN_W:0]         rnd_sum;
   logic signed [EW-1:0]   rnd_exp;
   logic [W-1:0]           rnd_prod;
   logic [3:0]             rnd_flags;

   assign ea = flp_a[W-2:MAN_W];
   assign eb = flp_b[W-2:MAN_W];
   assign fa = flp_a[MAN_W-1:0];
   assign fb = flp_b[MAN_W-1:0];

   // Subnormals (exp==0) are deliberately folded into zero.
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_inf   = (&ea) && (fa == '0);
   assign b_inf   = (&eb) && (fb == '0);
   assign a_nan   = (&ea) && (fa != '0);
   assign b_nan   = (&eb) && (fb != '0);
   assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
   assign accept  = in_valid && (state == S_IDLE);

   // Result for operands that bypass the multiplier entirely.
   always_comb begin
      spec_prod = {flp_a[W-1] ^ flp_b[W-1], {(W-1){1'b0}}};
      spec_inv  = 1'b0;
      if (a_nan || b_nan) begin
         spec_prod = QNAN;
      end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
         spec_prod = QNAN;
         spec_inv  = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_prod = {flp_a[W-1] ^ flp_b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // One shift-add step: multiplier bits sit in the low half and are consumed LSB first.
   assign mul_sum = {1'b0, prod_r[PW-1:SW]} + (prod_r[0] ? {1'b0, ma_r} : {(SW+1){1'b0}});

   assign norm_msb    = prod_r[PW-1];
   assign norm_frac   = norm_msb ? prod_r[PW-2:SW]  : prod_r[PW-3:SW-1];
   assign norm_guard  = norm_msb ? prod_r[SW-1]     : prod_r[SW-2];
   assign norm_sticky = norm_msb ? |prod_r[SW-2:0]  : |prod_r[SW-3:0];

   // A carry out of the fraction can only come from all-ones, leaving a zero fraction.
   assign round_up = guard_r & (sticky_r | frac_r[0]);
   assign rnd_sum  = {1'b0, frac_r} + {{MAN_W{1'b0}}, round_up};
   assign rnd_exp  = exp_r + $signed({{(EW-1){1'b0}}, rnd_sum[MAN_W]});

   always_comb begin
      rnd_prod  = {sign_r, rnd_exp[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
      rnd_flags = {3'b000, guard_r | sticky_r};
      if (rnd_exp >= EMAX) begin
         rnd_prod  = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flags = 4'b1001;
      end else if (rnd_exp[EW-1] || (rnd_exp == '0)) begin
         rnd_prod  = {sign_r, {(W-1){1'b0}}};
         rnd_flags = 4'b0101;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = special ? S_DONE : S_MUL;
         S_MUL:   if (cnt_r == LAST_ITER) next_state = S_NORM;
         S_NORM:  next_state = S_RND;
         S_RND:   next_state = S_DONE;
         S_DONE:  if (out_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // State register plus the datapath registers each state advances.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         sign_r    <= 1'b0;
         ma_r      <= '0;
         prod_r    <= '0;
         cnt_r     <= '0;
         exp_r     <= '0;
         frac_r    <= '0;
         guard_r   <= 1'b0;
         sticky_r  <= 1'b0;
         product_r <= '0;
         flags_r   <= '0;
      end else begin
         state <= next_state;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sign_r <= flp_a[W-1] ^ flp_b[W-1];
                  ma_r   <= {1'b1, fa};
                  prod_r <= {{SW{1'b0}}, 1'b1, fb};
                  cnt_r  <= '0;
                  exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                  if (special) begin
                     product_r <= spec_prod;
                     flags_r   <= {2'b00, spec_inv, 1'b0};
                  end
               end
            end
            S_MUL: begin
               prod_r <= {mul_sum, prod_r[SW-1:1]};
               cnt_r  <= cnt_r + CW'(1);
            end
            S_NORM: begin
               frac_r   <= norm_frac;
               guard_r  <= norm_guard;
               sticky_r <= norm_sticky;
               exp_r    <= exp_r + $signed({{(EW-1){1'b0}}, norm_msb});
            end
            S_RND: begin
               product_r <= rnd_prod;
               flags_r   <= rnd_flags;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign product   = product_r;
   assign flag_ovf  = flags_r[3];
   assign flag_unf  = flags_r[2];
   assign flag_inv  = flags_r[1];
   assign flag_inx  = flags_r[0];

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq (binary32): directed vectors, random
// operands against an integer rounding model, backpressure and mid-op reset.
module tb_fp_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid, outReady;
   logic [31:0] flpA, flpB;
   logic        inReady, outValid;
   logic [31:0] product;
   logic        flagOvf, flagUnf, flagInv, flagInx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   always #5 clk = ~clk;

   fp_mul_seq dut (
      .clk(clk), .reset(reset),
      .in_valid(inValid), .in_ready(inReady),
      .flp_a(flpA), .flp_b(flpB),
      .out_valid(outValid), .out_ready(outReady),
      .product(product),
      .flag_ovf(flagOvf), .flag_unf(flagUnf), .flag_inv(flagInv), .flag_inx(flagInx)
   );

   // Compare one value against its expectation and keep the tallies.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Offer one operation, scramble the operand bus after acceptance, and wait
   // (bounded) for out_valid; lat counts edges after the accepting edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] gotP, output logic [3:0] gotF,
                                output int lat);
      int w = 0;
      while (!inReady && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      flpA = a; flpB = b; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      flpA = $urandom; flpB = $urandom;
      lat = 0;
      while (!outValid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      gotP = product;
      gotF = {flagOvf, flagUnf, flagInv, flagInx};
   endtask

   // Exact-integer reference: full product, then divide by a power of two with
   // remainder-based nearest-even rounding.
   function automatic void refMul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic [3:0] f);
      int ea, eb, e, sh;
      logic s;
      bit aZero, bZero, aInf, bInf, aNan, bNan;
      longint unsigned ma, mb, pr, q, rem, half;
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      s = a[31] ^ b[31];
      aZero = (ea == 0); bZero = (eb == 0);
      aInf = (ea == 255) && (a[22:0] == 0); bInf = (eb == 255) && (b[22:0] == 0);
      aNan = (ea == 255) && (a[22:0] != 0); bNan = (eb == 255) && (b[22:0] != 0);
      f = 4'b0000;
      p = {s, 31'h0};
      if (aNan || bNan) begin
         p = 32'h7FC00000;
      end else if ((aZero && bInf) || (aInf && bZero)) begin
         p = 32'h7FC00000;
         f = 4'b0010;
      end else if (aInf || bInf) begin
         p = {s, 8'hFF, 23'h0};
      end else if (!(aZero || bZero)) begin
         ma = {1'b1, a[22:0]};
         mb = {1'b1, b[22:0]};
         pr = ma * mb;
         sh = (pr >= (64'd1 << 47)) ? 24 : 23;
         e = ea + eb - 127 + (sh - 23);
         q = pr >> sh;
         rem = pr - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
         end
         if (e >= 255) begin
            p = {s, 8'hFF, 23'h0};
            f = 4'b1001;
         end else if (e <= 0) begin
            p = {s, 31'h0};
            f = 4'b0101;
         end else begin
            p = {s, 8'(e), q[22:0]};
            f = {3'b000, rem != 0};
         end
      end
   endfunction

   function automatic logic [31:0] randOperand();
      logic [7:0]  e;
      logic [22:0] m;
      int r = $urandom_range(0, 19);
      if (r == 0)      e = 8'h00;
      else if (r == 1) e = 8'hFF;
      else if (r < 15) e = 8'($urandom_range(100, 155));
      else             e = 8'($urandom_range(1, 254));
      m = 23'($urandom);
      if ($urandom_range(0, 7) == 0) m = 23'($urandom_range(0, 3));
      return {1'($urandom_range(0, 1)), e, m};
   endfunction

   function automatic bit isSpecial(input logic [31:0] x);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
   endfunction

   vec_t        vecs[11];
   logic [31:0] gotP, expP;
   logic [3:0]  gotF, expF;
   int          lat;

   initial begin
      vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26};
      vecs[1]  = '{32'hBFC00000, 32'hC0200000, 32'h40700000, 4'b0000, 26};
      vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26};
      vecs[3]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b1001, 26};
      vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0101, 26};
      vecs[5]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b0010, 0};
      vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 0};
      vecs[7]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 0};
      vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0};
      vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0};
      vecs[10] = '{32'h80400000, 32'h7F800000, 32'h7FC00000, 4'b0010, 0};

      reset = 1'b1; inValid = 1'b0; outReady = 1'b1; flpA = '0; flpB = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("reset in_ready", 32'(inReady), 32'd1);
      checkOutput("reset out_valid", 32'(outValid), 32'd0);
      checkOutput("reset product", product, 32'h0);
      checkOutput("reset flags", 32'({flagOvf, flagUnf, flagInv, flagInx}), 32'd0);

      // Directed vectors, result taken immediately with out_ready high.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, gotP, gotF, lat);
         checkOutput($sformatf("vec%0d product", i), gotP, vecs[i].p);
         checkOutput($sformatf("vec%0d flags", i), 32'(gotF), 32'(vecs[i].f));
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         @(posedge clk); #1;
         checkOutput($sformatf("vec%0d in_ready after handshake", i), 32'(inReady), 32'd1);
      end

      // Random operands against the reference model.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a, b;
         a = randOperand();
         b = randOperand();
         refMul(a, b, expP, expF);
         applyStimulus(a, b, gotP, gotF, lat);
         checkOutput($sformatf("rand%0d %h*%h product", i, a, b), gotP, expP);
         checkOutput($sformatf("rand%0d %h*%h flags", i, a, b), 32'(gotF), 32'(expF));
         checkOutput($sformatf("rand%0d latency", i), 32'(lat),
                     (isSpecial(a) || isSpecial(b)) ? 32'd0 : 32'd26);
         @(posedge clk); #1;
      end

      // Backpressure: result and flags must hold while the consumer stalls.
      outReady = 1'b0;
      applyStimulus(32'h3F800001, 32'h3F800001, gotP, gotF, lat);
      checkOutput("bp product", gotP, 32'h3F800002);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("bp hold%0d product", i), product, 32'h3F800002);
         checkOutput($sformatf("bp hold%0d ovalid/iready/flags", i),
                     32'({outValid, inReady, flagOvf, flagUnf, flagInv, flagInx}), 32'b100001);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp release out_valid", 32'(outValid), 32'd0);
      checkOutput("bp release in_ready", 32'(inReady), 32'd1);

      // Asynchronous reset in the middle of the multiply loop.
      flpA = 32'h3FC00000; flpB = 32'h40000000; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checkOutput("midreset out_valid", 32'(outValid), 32'd0);
      checkOutput("midreset in_ready", 32'(inReady), 32'd1);
      checkOutput("midreset product", product, 32'h0);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      applyStimulus(32'h40400000, 32'h3F000000, gotP, gotF, lat);
      checkOutput("postreset product", gotP, 32'h3FC00000);
      checkOutput("postreset flags", 32'(gotF), 32'd0);
      checkOutput("postreset latency", 32'(lat), 32'd26);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
